// File: rtl/mem_access_pkg.sv
// Shared sizes and state encoding for the delayed memory-access drain path.
package mem_access_pkg;

   localparam int SIZE_COUNT   = 16;
   localparam int SIZE_RAM_LOG = 5;
   localparam int SIZE_ADDR    = 32;

   // Width of one FIFO head bundle: bank select plus in-time and out-time.
   localparam int SIZE_BUNDLE  = SIZE_RAM_LOG + 2 * SIZE_COUNT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2
   } state_t;

endpackage

// File: rtl/time_due_cmp.sv
// Wrap-safe "has count reached stamp" compare on free-running time stamps.
// Valid while stamp lies within half the counter range of count.
module time_due_cmp
   import mem_access_pkg::*;
#(
   parameter int W = SIZE_COUNT
) (
   input  logic [W-1:0] count,
   input  logic [W-1:0] stamp,
   output logic         due
);

   logic [W-1:0] diff;

   // Modular difference; a clear sign bit means count is at or past stamp.
   always_comb begin
      diff = count - stamp;
      due  = ~diff[W-1];
   end

endmodule

// File: rtl/mem_access_drain.sv
// Read-side engine of the delayed memory-access FIFO: pops the head, holds it
// until its out-time, issues it with valid/ready and reports latency/lateness.
module mem_access_drain
   import mem_access_pkg::*;
#(
   parameter int SIZE_COUNT   = mem_access_pkg::SIZE_COUNT,
   parameter int SIZE_RAM_LOG = mem_access_pkg::SIZE_RAM_LOG,
   parameter int SIZE_ADDR    = mem_access_pkg::SIZE_ADDR
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall_i,
   input  logic [SIZE_COUNT-1:0]   count,
   input  logic                    head_valid_i,
   input  logic [SIZE_RAM_LOG-1:0] head_ram_i,
   input  logic [SIZE_COUNT-1:0]   head_in_time_i,
   input  logic [SIZE_COUNT-1:0]   head_out_time_i,
   input  logic [SIZE_ADDR-1:0]    head_addr_i,
   output logic                    o,
   output logic                    req_valid_o,
   input  logic                    req_ready_i,
   output logic [SIZE_RAM_LOG-1:0] req_ram_o,
   output logic [SIZE_ADDR-1:0]    req_addr_o,
   output logic                    lat_valid_o,
   output logic [SIZE_COUNT-1:0]   lat_o,
   output logic [SIZE_COUNT-1:0]   late_o
);

   // Index 0 compares against the latched entry, index 1 against the FIFO head.
   localparam int CMP_CUR  = 0;
   localparam int CMP_HEAD = 1;

   state_t                  state_reg;
   logic [SIZE_RAM_LOG-1:0] ram_reg;
   logic [SIZE_COUNT-1:0]   in_time_reg;
   logic [SIZE_COUNT-1:0]   out_time_reg;
   logic [SIZE_ADDR-1:0]    addr_reg;
   logic                    req_valid_reg;
   logic                    lat_valid_reg;
   logic [SIZE_COUNT-1:0]   lat_reg;
   logic [SIZE_COUNT-1:0]   late_reg;

   logic [SIZE_COUNT-1:0]   stamp [2];
   logic [1:0]              due_vec;
   logic                    due_cur;
   logic                    due_head;
   logic                    handshake;
   logic                    latch;
   logic [SIZE_COUNT-1:0]   late_diff;
   logic [SIZE_COUNT-1:0]   lat_diff;

   assign stamp[CMP_CUR]  = out_time_reg;
   assign stamp[CMP_HEAD] = head_out_time_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_due
         time_due_cmp #(
            .W (SIZE_COUNT)
         ) u_due (
            .count (count),
            .stamp (stamp[gi]),
            .due   (due_vec[gi])
         );
      end
   endgenerate

   // Handshake and pop decision; a pop can only happen when the slot is free
   // or is being freed this very cycle, and never while stalled or in reset.
   always_comb begin
      due_cur   = due_vec[CMP_CUR];
      due_head  = due_vec[CMP_HEAD];
      handshake = req_valid_reg & req_ready_i;
      latch     = head_valid_i & ~stall_i & ~reset &
                  ((state_reg == IDLE) | ((state_reg == ISSUE) & handshake));
      late_diff = count - out_time_reg;
      lat_diff  = count - in_time_reg;
   end

   assign o           = latch;
   assign req_valid_o = req_valid_reg;
   assign req_ram_o   = ram_reg;
   assign req_addr_o  = addr_reg;
   assign lat_valid_o = lat_valid_reg;
   assign lat_o       = lat_reg;
   assign late_o      = late_reg;

   // Entry capture on pop and latency/lateness capture on handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_reg       <= '0;
         in_time_reg   <= '0;
         out_time_reg  <= '0;
         addr_reg      <= '0;
         lat_valid_reg <= 1'b0;
         lat_reg       <= '0;
         late_reg      <= '0;
      end else begin
         lat_valid_reg <= handshake;
         if (handshake) begin
            lat_reg  <= lat_diff;
            late_reg <= due_cur ? late_diff : '0;
         end
         if (latch) begin
            ram_reg      <= head_ram_i;
            in_time_reg  <= head_in_time_i;
            out_time_reg <= head_out_time_i;
            addr_reg     <= head_addr_i;
         end
      end
   end

   // Drain FSM: IDLE -> (WAIT until due) -> ISSUE until handshake, chaining
   // straight into the next head when it is popped in the handshake cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         req_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (latch) begin
                  state_reg     <= due_head ? ISSUE : WAIT;
                  req_valid_reg <= due_head;
               end
            end
            WAIT: begin
               if (~stall_i & due_cur) begin
                  state_reg     <= ISSUE;
                  req_valid_reg <= 1'b1;
               end
            end
            ISSUE: begin
               if (handshake) begin
                  if (latch) begin
                     state_reg     <= due_head ? ISSUE : WAIT;
                     req_valid_reg <= due_head;
                  end else begin
                     state_reg     <= IDLE;
                     req_valid_reg <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg     <= IDLE;
               req_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_drain.sv
// Directed bench for mem_access_drain: each task drives one scenario and checks
// hand-computed outputs one tick after the clock edge.
module tb_mem_access_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic [15:0] count;
   logic        head_valid_i;
   logic [4:0]  head_ram_i;
   logic [15:0] head_in_time_i;
   logic [15:0] head_out_time_i;
   logic [31:0] head_addr_i;
   logic        o;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [4:0]  req_ram_o;
   logic [31:0] req_addr_o;
   logic        lat_valid_o;
   logic [15:0] lat_o;
   logic [15:0] late_o;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mem_access_drain dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall_i),
      .count           (count),
      .head_valid_i    (head_valid_i),
      .head_ram_i      (head_ram_i),
      .head_in_time_i  (head_in_time_i),
      .head_out_time_i (head_out_time_i),
      .head_addr_i     (head_addr_i),
      .o               (o),
      .req_valid_o     (req_valid_o),
      .req_ready_i     (req_ready_i),
      .req_ram_o       (req_ram_o),
      .req_addr_o      (req_addr_o),
      .lat_valid_o     (lat_valid_o),
      .lat_o           (lat_o),
      .late_o          (late_o)
   );

   // One clock: wait past the edge, then advance the free-running counter.
   task automatic step();
      @(posedge clk);
      #1;
      count = count + 16'd1;
   endtask

   task automatic set_head(input logic v, input logic [4:0] ram, input logic [15:0] tin,
                           input logic [15:0] tout, input logic [31:0] addr);
      head_valid_i    = v;
      head_ram_i      = ram;
      head_in_time_i  = tin;
      head_out_time_i = tout;
      head_addr_i     = addr;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_i = 1'b0; count = 16'd0; req_ready_i = 1'b0;
      set_head(1'b0, 5'd0, 16'd0, 16'd0, 32'd0);
      step(); step();
      reset = 1'b0; #1;
      tests_run++;
      if ({o, req_valid_o, lat_valid_o, req_ram_o, req_addr_o, lat_o, late_o} !== 72'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h required 0",
                  {o, req_valid_o, lat_valid_o, req_ram_o, req_addr_o, lat_o, late_o});
      end
      $display("[TB] reset: outputs=%h", {o, req_valid_o, lat_valid_o, req_ram_o, req_addr_o});
   endtask

   task automatic test_single();
      int n;
      count = 16'd100; req_ready_i = 1'b1;
      set_head(1'b1, 5'd3, 16'd100, 16'd110, 32'h0000_A000);
      #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL single_pop: o=%b required 1", o);
      end
      step(); head_valid_i = 1'b0; #1;
      tests_run++;
      if ({o, req_valid_o} !== 2'b00) begin
         tests_failed++; $display("FAIL single_wait: o,req_valid=%b required 00", {o, req_valid_o});
      end
      n = 0;
      while (req_valid_o !== 1'b1 && n < 30) begin
         step(); #1; n++;
      end
      tests_run++;
      if (req_valid_o !== 1'b1 || count !== 16'd111) begin
         tests_failed++;
         $display("FAIL single_issue_time: req_valid=%b at count=%0d required 1 at 111", req_valid_o, count);
      end
      tests_run++;
      if ({req_ram_o, req_addr_o} !== {5'd3, 32'h0000_A000}) begin
         tests_failed++;
         $display("FAIL single_req_fields: ram=%0d addr=%h required 3 0000a000", req_ram_o, req_addr_o);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, req_valid_o, lat_o, late_o} !== {1'b1, 1'b0, 16'd11, 16'd1}) begin
         tests_failed++;
         $display("FAIL single_lat: lv=%b rv=%b lat=%0d late=%0d required 1 0 11 1",
                  lat_valid_o, req_valid_o, lat_o, late_o);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, lat_o, late_o} !== {1'b0, 16'd11, 16'd1}) begin
         tests_failed++;
         $display("FAIL single_lat_hold: lv=%b lat=%0d late=%0d required 0 11 1", lat_valid_o, lat_o, late_o);
      end
      $display("[TB] single: lat=%0d late=%0d", lat_o, late_o);
   endtask

   task automatic test_due();
      count = 16'd100; req_ready_i = 1'b1;
      set_head(1'b1, 5'd9, 16'd95, 16'd90, 32'h0000_B0B0);
      #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL due_pop: o=%b required 1", o);
      end
      step(); head_valid_i = 1'b0; #1;
      tests_run++;
      if ({req_valid_o, req_ram_o, req_addr_o} !== {1'b1, 5'd9, 32'h0000_B0B0}) begin
         tests_failed++;
         $display("FAIL due_issue: rv=%b ram=%0d addr=%h required 1 9 0000b0b0", req_valid_o, req_ram_o, req_addr_o);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, req_valid_o, lat_o, late_o} !== {1'b1, 1'b0, 16'd6, 16'd11}) begin
         tests_failed++;
         $display("FAIL due_lat: lv=%b rv=%b lat=%0d late=%0d required 1 0 6 11",
                  lat_valid_o, req_valid_o, lat_o, late_o);
      end
      $display("[TB] due: lat=%0d late=%0d", lat_o, late_o);
   endtask

   task automatic test_wrap();
      int n;
      count = 16'hFFFA; req_ready_i = 1'b1;
      set_head(1'b1, 5'd4, 16'hFFF8, 16'h0005, 32'h0000_C0DE);
      #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL wrap_pop: o=%b required 1", o);
      end
      step(); head_valid_i = 1'b0; #1;
      n = 0;
      while (req_valid_o !== 1'b1 && n < 30) begin
         step(); #1; n++;
      end
      tests_run++;
      if (req_valid_o !== 1'b1 || count !== 16'h0006) begin
         tests_failed++;
         $display("FAIL wrap_issue_time: req_valid=%b at count=%h required 1 at 0006", req_valid_o, count);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, lat_o, late_o} !== {1'b1, 16'h000E, 16'h0001}) begin
         tests_failed++;
         $display("FAIL wrap_lat: lv=%b lat=%h late=%h required 1 000e 0001", lat_valid_o, lat_o, late_o);
      end
      $display("[TB] wrap: lat=%0d late=%0d", lat_o, late_o);
   endtask

   task automatic test_back_to_back();
      count = 16'd300; req_ready_i = 1'b0;
      set_head(1'b1, 5'd1, 16'd290, 16'd290, 32'h0000_1111);
      #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL bp_pop_a: o=%b required 1", o);
      end
      step();
      set_head(1'b1, 5'd2, 16'd295, 16'd300, 32'h0000_2222);
      #1;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if ({o, req_valid_o, req_ram_o, req_addr_o} !== {1'b0, 1'b1, 5'd1, 32'h0000_1111}) begin
            tests_failed++;
            $display("FAIL bp_hold_%0d: o=%b rv=%b ram=%0d addr=%h required 0 1 1 00001111",
                     i, o, req_valid_o, req_ram_o, req_addr_o);
         end
         step(); #1;
      end
      req_ready_i = 1'b1; #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL bp_pop_b: o=%b required 1 in handshake cycle", o);
      end
      step(); head_valid_i = 1'b0; #1;
      tests_run++;
      if ({lat_valid_o, lat_o, late_o, req_valid_o, req_ram_o, req_addr_o} !==
          {1'b1, 16'd14, 16'd14, 1'b1, 5'd2, 32'h0000_2222}) begin
         tests_failed++;
         $display("FAIL bp_first_done: lv=%b lat=%0d late=%0d rv=%b ram=%0d addr=%h required 1 14 14 1 2 00002222",
                  lat_valid_o, lat_o, late_o, req_valid_o, req_ram_o, req_addr_o);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, lat_o, late_o, req_valid_o} !== {1'b1, 16'd10, 16'd5, 1'b0}) begin
         tests_failed++;
         $display("FAIL bp_second_done: lv=%b lat=%0d late=%0d rv=%b required 1 10 5 0",
                  lat_valid_o, lat_o, late_o, req_valid_o);
      end
      $display("[TB] back_to_back: lat=%0d late=%0d", lat_o, late_o);
   endtask

   task automatic test_stall();
      count = 16'd400; stall_i = 1'b1; req_ready_i = 1'b1;
      set_head(1'b1, 5'd6, 16'd400, 16'd405, 32'h0000_6666);
      #1;
      tests_run++;
      if (o !== 1'b0) begin
         tests_failed++; $display("FAIL stall_no_pop: o=%b required 0", o);
      end
      step(); #1;
      tests_run++;
      if ({o, req_valid_o} !== 2'b00) begin
         tests_failed++; $display("FAIL stall_idle_hold: o,rv=%b required 00", {o, req_valid_o});
      end
      stall_i = 1'b0; #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL stall_release_pop: o=%b required 1", o);
      end
      step(); head_valid_i = 1'b0; stall_i = 1'b1; #1;
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if ({o, req_valid_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_wait_%0d: o,rv=%b at count=%0d required 00", i, {o, req_valid_o}, count);
         end
         step(); #1;
      end
      stall_i = 1'b0;
      step(); #1;
      tests_run++;
      if ({req_valid_o, req_ram_o} !== {1'b1, 5'd6}) begin
         tests_failed++;
         $display("FAIL stall_issue: rv=%b ram=%0d at count=%0d required 1 6", req_valid_o, req_ram_o, count);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, lat_o, late_o} !== {1'b1, 16'd9, 16'd4}) begin
         tests_failed++;
         $display("FAIL stall_lat: lv=%b lat=%0d late=%0d required 1 9 4", lat_valid_o, lat_o, late_o);
      end
      $display("[TB] stall: lat=%0d late=%0d", lat_o, late_o);
   endtask

   task automatic test_reset_mid();
      count = 16'd500; req_ready_i = 1'b0;
      set_head(1'b1, 5'd7, 16'd490, 16'd490, 32'h0000_7777);
      #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL rst_pop: o=%b required 1", o);
      end
      step();
      set_head(1'b1, 5'd5, 16'd500, 16'd495, 32'h0000_5555);
      #1;
      tests_run++;
      if ({o, req_valid_o, req_ram_o} !== {1'b0, 1'b1, 5'd7}) begin
         tests_failed++;
         $display("FAIL rst_issue: o=%b rv=%b ram=%0d required 0 1 7", o, req_valid_o, req_ram_o);
      end
      reset = 1'b1;
      step(); #1;
      tests_run++;
      if ({o, req_valid_o, lat_valid_o, req_ram_o, req_addr_o, lat_o, late_o} !== 72'd0) begin
         tests_failed++;
         $display("FAIL rst_outputs: got %h required 0",
                  {o, req_valid_o, lat_valid_o, req_ram_o, req_addr_o, lat_o, late_o});
      end
      reset = 1'b0; head_valid_i = 1'b0;
      step(); #1;
      tests_run++;
      if ({o, req_valid_o, lat_valid_o} !== 3'b000) begin
         tests_failed++;
         $display("FAIL rst_after: o,rv,lv=%b required 000", {o, req_valid_o, lat_valid_o});
      end
      head_valid_i = 1'b1; req_ready_i = 1'b1; #1;
      tests_run++;
      if (o !== 1'b1) begin
         tests_failed++; $display("FAIL rst_repop: o=%b required 1", o);
      end
      step(); head_valid_i = 1'b0; #1;
      tests_run++;
      if ({req_valid_o, req_ram_o, req_addr_o} !== {1'b1, 5'd5, 32'h0000_5555}) begin
         tests_failed++;
         $display("FAIL rst_new_entry: rv=%b ram=%0d addr=%h required 1 5 00005555",
                  req_valid_o, req_ram_o, req_addr_o);
      end
      step(); #1;
      tests_run++;
      if ({lat_valid_o, lat_o, late_o} !== {1'b1, 16'd4, 16'd9}) begin
         tests_failed++;
         $display("FAIL rst_lat: lv=%b lat=%0d late=%0d required 1 4 9", lat_valid_o, lat_o, late_o);
      end
      $display("[TB] reset_mid: lat=%0d late=%0d", lat_o, late_o);
   endtask

   initial begin
      test_reset();
      test_single();
      test_due();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
